xor_acc_arbiter: RTL

Round-robin arbiter and sequencer that shares a single XOR-accumulate register, an XOR stage feeding a D flip-flop bank, among N requesters. Each requester posts a data word with a level `req` and holds it until `ack`; the controller grants one requester at a time, folds the granted word into the shared accumulator (`acc <= acc ^ data`) and counts completed operations. It sits between the requester agents and the shared XOR/register datapath and is the only writer of that register.

---
 rtl/xor_acc_arbiter_pkg.sv | 14 +
 rtl/xor_acc_arbiter_if.sv | 34 +++
 rtl/xor_acc_arbiter_rr_pick.sv | 28 ++
 rtl/xor_acc_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/xor_acc_arbiter_pkg.sv
// Shared types and constants for the XOR-accumulate arbiter.
package arb_pkg;

    localparam int ARB_N = 4;
    localparam int ARB_W = 8;
    localparam int OPS_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_e;

endpackage

// File: rtl/xor_acc_arbiter_if.sv
// Requester-side bus of the arbiter: request/data/clear in, grant/ack/status out.
interface xor_acc_arbiter_if #(
    parameter int N = arb_pkg::ARB_N,
    parameter int W = arb_pkg::ARB_W
);
    import arb_pkg::*;

    localparam int LW = $clog2(N);

    // Handshake: a requester raises req[i] with data[i*W +: W] and holds both
    // stable until it sees ack[i] (one cycle); it then drops req[i]. Dropping
    // req[i] while gnt[i] is high abandons the operation with no ack.
    logic [N-1:0]     req;
    logic [N*W-1:0]   data;
    logic             clr;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic [W-1:0]     acc;
    logic [LW-1:0]    owner;
    logic             busy;
    logic [OPS_W-1:0] ops;
    state_e           dbg_state;

    modport master (
        output req, data, clr,
        input  gnt, ack, acc, owner, busy, ops, dbg_state
    );

    modport slave (
        input  req, data, clr,
        output gnt, ack, acc, owner, busy, ops, dbg_state
    );

endinterface

// File: rtl/xor_acc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr, with wrap.
module rr_pick #(
    parameter int N  = arb_pkg::ARB_N,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_ptr,
    output logic [LW-1:0] o_win,
    output logic          o_any
);

    logic [LW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        o_win = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = LW'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_win = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/xor_acc_arbiter.sv
// Round-robin sequencer that is the sole writer of a shared XOR-accumulate register.
module xor_acc_arbiter #(
    parameter int N = arb_pkg::ARB_N,
    parameter int W = arb_pkg::ARB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    xor_acc_arbiter_if.slave  bus
);
    import arb_pkg::*;

    localparam int LW = $clog2(N);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     r_ack;
    logic [N-1:0]     w_gnt_nxt;
    logic [N-1:0]     w_ack_nxt;
    logic [W-1:0]     r_acc;
    logic [LW-1:0]    r_owner;
    logic [LW-1:0]    r_ptr;
    logic [OPS_W-1:0] r_ops;
    logic [LW-1:0]    w_win;
    logic             w_any;
    logic             w_load_owner;
    logic             w_complete;
    logic             w_rotate;
    logic [W-1:0]     w_word;

    rr_pick #(.N(N), .LW(LW)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == LW'(i)) begin
                w_word = bus.data[i*W +: W];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_ack_nxt    = r_ack;
        w_load_owner = 1'b0;
        w_complete   = 1'b0;
        w_rotate     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = N'(1) << w_win;
                    w_load_owner = 1'b1;
                end
            end
            GRANT: begin
                w_gnt_nxt = '0;
                // A requester that lets go during its grant forfeits the slot.
                if (bus.req[r_owner]) begin
                    w_state_nxt = ACK;
                    w_ack_nxt   = N'(1) << r_owner;
                    w_complete  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
                w_ack_nxt   = '0;
                w_rotate    = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_ack_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_acc   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_ops   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            if (w_load_owner) begin
                r_owner <= w_win;
            end
            if (w_rotate) begin
                r_ptr <= (r_owner == LW'(N - 1)) ? '0 : r_owner + 1'b1;
            end
            if (w_complete) begin
                r_ops <= r_ops + 1'b1;
            end
            // Clear beats a same-cycle fold: the word is dropped, the op still counts.
            if (bus.clr) begin
                r_acc <= '0;
            end else if (w_complete) begin
                r_acc <= r_acc ^ w_word;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.acc       = r_acc;
    assign bus.owner     = r_owner;
    assign bus.ops       = r_ops;
    assign bus.busy      = (r_state != IDLE);
    assign bus.dbg_state = r_state;

endmodule
